// File: rtl/seq_mul_if.sv
// Start/busy/done handshake bundle between the ALU controller and seq_mul.
// The controller drives operands and start; the multiplier returns status and product.
interface seq_mul_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (output start, sgn, a, b, input busy, done, prod);
  modport slave  (input start, sgn, a, b, output busy, done, prod);
endinterface

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned.
// Operands are reduced to magnitudes on accept; the sign is reapplied on the last step.
module seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_mul_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [KW-1:0]    k_q, k_d;

  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // The most-negative operand negates to itself, which read unsigned is its magnitude.
  always_comb begin
    in_mag_a = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    in_mag_b = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    addend   = mag_b_q[k_q] ? ({{WIDTH{1'b0}}, mag_a_q} << k_q) : '0;
    acc_sum  = acc_q + addend;
  end

  // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    k_d     = k_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          neg_d   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          prod_d  = neg_q ? -acc_sum : acc_sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      k_q     <= k_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.prod = prod_q;

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Parametrised sequential shift-add multiplier for the ALU datapath. It is the clocked successor to the combinational 4-bit multiplier.
- Processes one multiplier bit per clock. Supports unsigned and two's-complement signed operands, selected per operation.
- Uses a start/busy/done handshake so the ALU controller can issue operations and collect results.
- Result is the full 2*WIDTH-bit product, held stable until the next accepted operation.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32). Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sgn  input  1  1 = operands are signed two's complement; 0 = unsigned; latched with operands
- a  input  WIDTH  multiplicand, latched on accepted start
- b  input  WIDTH  multiplier, latched on accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  single-cycle pulse: prod is valid this cycle
- prod  output  2*WIDTH  product; holds last result until the next completion

Behaviour:
- Reset: one clock and reset only. Reset is synchronous and active-high (rst sampled on the clk rising edge).
  - State returns to IDLE.
  - busy=0, done=0, prod=0; internal accumulator, counter and latched operands are cleared.
  - A reset during RUN aborts the operation: no done pulse, and prod is forced to 0.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 latches a, b, sgn → RUN.
  - RUN: busy=1, done=0. Runs WIDTH iterations, counter k = 0..WIDTH-1. Each cycle: if mag_b[k]=1, acc += mag_a << k (acc is 2*WIDTH bits). After k=WIDTH-1 → DONE. start is ignored in RUN (no queueing).
  - DONE: busy=0, done=1 for exactly one cycle. prod is updated in the transition into DONE, so it is valid in the same cycle done=1. Next state: start=1 re-arms exactly as in IDLE (back-to-back, no idle gap), else → IDLE.
- Latency:
  - Start accepted at edge N; busy=1 for edges N+1..N+WIDTH; done=1 after edge N+WIDTH+1.
  - Latency is fixed at WIDTH+1 cycles regardless of operand values; there is no early termination on zero bits.
  - Maximum throughput is one result per WIDTH+1 cycles.
- Arithmetic:
  - sgn=0: mag_a=a, mag_b=b (zero-extended). prod = a*b exactly; 2*WIDTH bits cannot overflow.
  - sgn=1: mag_x = |x| as an unsigned WIDTH-bit value. The most-negative value −2^(WIDTH-1) has magnitude 2^(WIDTH-1), which is representable unsigned. The result sign is a[MSB] XOR b[MSB]. If the sign is 1, prod = two's complement of acc, else prod = acc.
  - Full range is exact for sgn=1, including (−2^(WIDTH-1))², which is +2^(2*WIDTH-2) and fits.
  - A zero product is always 0, never negative zero; this follows naturally from two's complement of 0.
- prod stability:
  - prod only changes on a completion or a reset. It does not change during RUN, and does not change when inputs change or when start is ignored.
- Simultaneous events:
  - rst has priority over start and over completion.
  - start with busy=1 has no effect on state, operands or outputs.
- Inputs a, b, sgn are don't-care except in the cycle start is accepted.

Test Plan:
- WIDTH=4, sgn=0, a=15, b=15, start for 1 cycle: busy=1 for 4 cycles, then done pulse with prod=8'hE1 (225). prod is still 8'hE1 five cycles later.
- sgn=1, a=4'hD (−3), b=5 → prod=8'hF1 (−15). Same operands with sgn=0 → prod=8'h41 (65).
- sgn=1 corners:
  - a=4'h8, b=4'h8 → prod=8'h40 (+64).
  - a=4'h8, b=4'h7 → prod=8'hC8 (−56).
  - a=0, b=4'h9 → prod=8'h00.
- Handshake:
  - Pulse start again during RUN with different operands: ignored, and the first result completes correctly.
  - Assert start in the DONE cycle: the second operation is accepted with no IDLE gap, and its done arrives exactly 5 cycles later.
- Reset mid-operation: rst=1 at RUN cycle 2 → next cycle busy=0, done=0, prod=0, and no done pulse ever appears. A following start with a=3, b=6 (unsigned) → prod=8'h12.
- Randomised sweep at WIDTH=4 (exhaustive, both sgn values) and WIDTH=8 (10k vectors): prod matches the reference product, and latency is always WIDTH+1.
